scroll_ground: RTL and testbench

Parametrised, horizontally scrolling ground-strip renderer for the VGA pixel pipeline. Per pixel it decides whether the current screen position lies in a rectangular ground region, generates the address into an external 12-bit RGB sprite ROM with a wrapping per-frame scroll offset, and returns the aligned colour and an in-region flag. Its outputs feed the pixel-priority mux alongside the ghost and pipe layers.

---
 rtl/scroll_ground.sv | 107 ++++++++++
 tb/tb_scroll_ground.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/scroll_ground.sv
// Scrolling ground-strip renderer: region test, wrapped ROM addressing, latency-aligned colour out.
// Optional `define SCROLL_GROUND_TRANSP_EN makes ROM colour 12'hF0F transparent.
module scroll_ground #(
  parameter int          X0       = 350,
  parameter int          Y0       = 750,
  parameter int          W        = 740,
  parameter int          H        = 150,
  parameter int          ADDR_W   = 17,
  parameter int          ROM_LAT  = 1,
  parameter logic [11:0] BG_COLOR = 12'h7CC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [10:0]       pos_x,
  input  logic [10:0]       pos_y,
  input  logic              frame_start,
  input  logic              scroll_en,
  input  logic [3:0]        speed,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [11:0]       rom_data,
  output logic [3:0]        groundr,
  output logic [3:0]        groundg,
  output logic [3:0]        groundb,
  output logic              isground
);

  localparam logic [11:0]       X0_12  = 12'(X0);
  localparam logic [11:0]       Y0_12  = 12'(Y0);
  localparam logic [11:0]       XE_12  = 12'(X0 + W);
  localparam logic [11:0]       YE_12  = 12'(Y0 + H);
  localparam logic [11:0]       W_12   = 12'(W);
  localparam logic [ADDR_W-1:0] W_A    = ADDR_W'(W);

  logic [10:0]       off_reg;
  logic [11:0]       off_sum;
  logic [10:0]       off_next;
  logic              in_region;
  logic [11:0]       dx;
  logic [11:0]       col_sum;
  logic [11:0]       col;
  logic [7:0]        row;
  logic [ADDR_W-1:0] addr_next;
  logic [ROM_LAT:0]  flag_pipe_reg;
  logic              key_hit;
  logic              show;

  // Widen to 12 bits so X0+W / Y0+H never overflow the comparison.
  assign in_region = ({1'b0, pos_x} >= X0_12) && ({1'b0, pos_x} < XE_12) &&
                     ({1'b0, pos_y} >= Y0_12) && ({1'b0, pos_y} < YE_12);

  assign off_sum  = {1'b0, off_reg} + {8'b0, speed};
  assign off_next = (off_sum >= W_12) ? 11'(off_sum - W_12) : off_sum[10:0];

  assign dx        = {1'b0, pos_x} - X0_12;
  assign col_sum   = dx + {1'b0, off_reg};
  assign col       = (col_sum >= W_12) ? (col_sum - W_12) : col_sum;
  assign row       = 8'({1'b0, pos_y} - Y0_12);
  assign addr_next = in_region ? (ADDR_W'(row) * W_A + ADDR_W'(col)) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_reg  <= '0;
      rom_addr <= '0;
    end else begin
      rom_addr <= addr_next;
      if (frame_start && scroll_en)
        off_reg <= off_next;
    end
  end

  // Region flag rides beside the ROM access: one stage with rom_addr, then ROM_LAT more.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flag_pipe_reg[0] <= 1'b0;
    else        flag_pipe_reg[0] <= in_region;
  end

  genvar gi;
  generate
    for (gi = 1; gi <= ROM_LAT; gi++) begin : g_flag
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flag_pipe_reg[gi] <= 1'b0;
        else        flag_pipe_reg[gi] <= flag_pipe_reg[gi-1];
      end
    end
  endgenerate

`ifdef SCROLL_GROUND_TRANSP_EN
  assign key_hit = (rom_data == 12'hF0F);
`else
  assign key_hit = 1'b0;
`endif

  assign show = flag_pipe_reg[ROM_LAT] && !key_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isground <= 1'b0;
      groundr  <= '0;
      groundg  <= '0;
      groundb  <= '0;
    end else begin
      isground <= show;
      {groundr, groundg, groundb} <= show ? rom_data : BG_COLOR;
    end
  end

endmodule

// File: tb/tb_scroll_ground.sv
// Scoreboard bench for scroll_ground: driver pushes expected pixels, negedge monitor pops and checks.
module tb_scroll_ground #(parameter int LAT = 1);

  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [10:0]   pos_x = '0, pos_y = '0;
  logic          frame_start = 1'b0, scroll_en = 1'b0;
  logic [3:0]    speed = '0;
  logic [AW-1:0] rom_addr;
  logic [11:0]   rom_data;
  logic [3:0]    groundr, groundg, groundb;
  logic          isground;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          x;
    int          y;
    logic [12:0] exp;
  } pix_t;
  pix_t sb_q[$];

  logic            drv_valid = 1'b0;
  logic [LAT+1:0]  v_pipe;
  logic [11:0]     rom_q [LAT];

  always #5 clk = ~clk;

  scroll_ground #(.ROM_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .pos_x(pos_x), .pos_y(pos_y),
    .frame_start(frame_start), .scroll_en(scroll_en), .speed(speed),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .groundr(groundr), .groundg(groundg), .groundb(groundb), .isground(isground)
  );

  // ROM model: data = addr[11:0] (magenta key at addr 3 when transparency is built in)
  always @(posedge clk) begin
`ifdef SCROLL_GROUND_TRANSP_EN
    rom_q[0] <= (rom_addr == 17'd3) ? 12'hF0F : rom_addr[11:0];
`else
    rom_q[0] <= rom_addr[11:0];
`endif
    for (int i = 1; i < LAT; i++) rom_q[i] <= rom_q[i-1];
  end
  assign rom_data = rom_q[LAT-1];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) v_pipe <= '0;
    else        v_pipe <= {v_pipe[LAT:0], drv_valid};
  end

  always @(negedge clk) begin
    if (rst_n && v_pipe[LAT+1]) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL pix: output presented with empty scoreboard, got ig=%0b rgb=%h",
                 isground, {groundr, groundg, groundb});
      end else begin
        pix_t p;
        p = sb_q.pop_front();
        if ({isground, groundr, groundg, groundb} !== p.exp) begin
          failures++;
          $display("FAIL pix(%0d,%0d): got ig=%0b rgb=%h, expected ig=%0b rgb=%h",
                   p.x, p.y, isground, {groundr, groundg, groundb}, p.exp[12], p.exp[11:0]);
        end else
          $display("pix(%0d,%0d) ig=%0b rgb=%h ok", p.x, p.y, isground, {groundr, groundg, groundb});
      end
    end
  end

  function automatic logic [12:0] model(int x, int y, int off);
    int col, addr;
    logic [11:0] c;
    if (x < 350 || x >= 1090 || y < 750 || y >= 900) return {1'b0, 12'h7CC};
    col  = (x - 350 + off) % 740;
    addr = (y - 750) * 740 + col;
    c    = 12'(addr);
`ifdef SCROLL_GROUND_TRANSP_EN
    if (addr == 3) return {1'b0, 12'h7CC};
`endif
    return {1'b1, c};
  endfunction

  task automatic send(int x, int y, logic fs, logic [12:0] exp);
    pix_t p;
    pos_x = 11'(x); pos_y = 11'(y); frame_start = fs; drv_valid = 1'b1;
    p.x = x; p.y = y; p.exp = exp;
    sb_q.push_back(p);
    @(posedge clk); #1;
  endtask

  task automatic idle(int n);
    drv_valid = 1'b0; frame_start = 1'b0; pos_x = '0; pos_y = '0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse(int n);
    drv_valid = 1'b0; pos_x = '0; pos_y = '0;
    repeat (n) begin
      frame_start = 1'b1; @(posedge clk); #1;
      frame_start = 1'b0; @(posedge clk); #1;
    end
  endtask

  task automatic check_zero(string name);
    checks++;
    if ({isground, groundr, groundg, groundb} !== 13'd0 || rom_addr !== '0) begin
      failures++;
      $display("FAIL %s: got ig=%0b rgb=%h addr=%0d, expected all zero",
               name, isground, {groundr, groundg, groundb}, rom_addr);
    end else
      $display("%s: outputs zero ok", name);
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 20) begin @(posedge clk); #1; n++; end
    if (sb_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain: %0d pixels never appeared, expected 0 pending", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    rst_n = 1'b1;
    idle(1);

    // Corners with off = 0
    send(350, 750, 1'b0, {1'b1, 12'h000});
    send(1089, 899, 1'b0, {1'b1, 12'h197});
    send(349, 750, 1'b0, {1'b0, 12'h7CC});
    send(350, 900, 1'b0, {1'b0, 12'h7CC});
    send(1090, 750, 1'b0, {1'b0, 12'h7CC});
    send(350, 749, 1'b0, {1'b0, 12'h7CC});
`ifdef SCROLL_GROUND_TRANSP_EN
    send(352, 750, 1'b0, {1'b1, 12'h002});
    send(353, 750, 1'b0, {1'b0, 12'h7CC});
    send(354, 750, 1'b0, {1'b1, 12'h004});
`endif
    idle(1); drain();

    // Wrap: 74 * 10 = 740 returns off to 0, one more gives 10
    speed = 4'd10; scroll_en = 1'b1;
    pulse(74);
    send(350, 750, 1'b0, {1'b1, 12'h000});
    idle(1);
    pulse(1);
    send(1085, 750, 1'b0, {1'b1, 12'h005});
    send(350, 751, 1'b0, {1'b1, 12'h2EE});
    idle(1); drain();

    // Freeze: pulses with scroll_en low keep off = 10
    scroll_en = 1'b0;
    pulse(5);
    send(350, 750, 1'b0, {1'b1, 12'h00A});
    // Coincident frame_start: that pixel sees off = 10, the next sees 20
    scroll_en = 1'b1;
    send(350, 750, 1'b1, {1'b1, 12'h00A});
    send(350, 750, 1'b0, {1'b1, 12'h014});
    scroll_en = 1'b0;
    idle(1); drain();

    // Continuous ramp across the left edge, off = 20
    for (int x = 340; x <= 362; x++) send(x, 760, 1'b0, model(x, 760, 20));
    idle(1); drain();

    // Mid-line reset: outputs clear asynchronously, off returns to 0
    for (int x = 400; x < 404; x++) send(x, 800, 1'b0, model(x, 800, 20));
    #2 rst_n = 1'b0;
    #1 check_zero("midline_reset");
    sb_q.delete();
    drv_valid = 1'b0;
    @(posedge clk); #1;
    check_zero("reset_hold");
    rst_n = 1'b1;
    send(351, 750, 1'b0, {1'b1, 12'h001});
    send(500, 760, 1'b0, model(500, 760, 0));
    idle(1); drain();

    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
